// File: rtl/alu_if.sv
// Operand/opcode/result bundle for one alu instance.
// master drives operands, slave (the alu) returns the registered result.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opcode;
    logic [63:0] out;

    modport master (output a, output b, output opcode, input out);
    modport slave  (input a, input b, input opcode, output out);
endinterface

// File: rtl/alu.sv
// Single-cycle registered 32-bit ALU: integer ops plus binary32 add/subtract.
// All arithmetic is combinational into one output register (latency 1).
module alu (
    input  logic     clk,
    input  logic     rst,
    alu_if.slave     bus
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_FADD = 5'b00101;
    localparam logic [4:0] OP_FSUB = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SLT  = 5'b01010;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    // Round-to-nearest-even on a 27-bit {1.mant[23], G, R, S} value, then
    // map exponent overflow to Inf and anything below min normal to zero.
    function automatic logic [31:0] fp_round(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [26:0] m);
        logic [23:0]        mant;
        logic               up;
        logic [24:0]        m25;
        logic signed [9:0]  e2;
        logic [22:0]        frac;
        mant = m[26:3];
        up   = m[2] & (m[1] | m[0] | mant[0]);
        m25  = {1'b0, mant} + {24'b0, up};
        if (m25[24]) begin
            e2   = e + 10'sd1;
            frac = m25[23:1];
        end else begin
            e2   = e;
            frac = m25[22:0];
        end
        if (e2 >= 10'sd255)
            fp_round = {s, 8'hFF, 23'b0};
        else if (e2 <= 10'sd0)
            fp_round = {s, 31'b0};
        else
            fp_round = {s, e2[7:0], frac};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a,
                                           input logic [31:0] b);
        logic               sa, sb, sx, sy;
        logic [7:0]         ea, eb, ex, ey, d;
        logic [22:0]        fa, fb;
        logic [23:0]        mx, my;
        logic [26:0]        mx27, aligned, diff, norm;
        logic [53:0]        w;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic               found;
        logic signed [9:0]  e;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        fp_add = 32'b0;
        if ((ea == 8'hFF && fa != 23'b0) || (eb == 8'hFF && fb != 23'b0)) begin
            fp_add = FP_QNAN;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            fp_add = (sa == sb) ? a : FP_QNAN;
        end else if (ea == 8'hFF) begin
            fp_add = a;
        end else if (eb == 8'hFF) begin
            fp_add = b;
        end else if (ea == 8'h00 && eb == 8'h00) begin
            // Denormals count as signed zero; only -0 + -0 keeps the sign.
            fp_add = {sa & sb, 31'b0};
        end else if (ea == 8'h00) begin
            fp_add = b;
        end else if (eb == 8'h00) begin
            fp_add = a;
        end else begin
            if ({eb, fb} > {ea, fa}) begin
                sx = sb; ex = eb; mx = {1'b1, fb};
                sy = sa; ey = ea; my = {1'b1, fa};
            end else begin
                sx = sa; ex = ea; mx = {1'b1, fa};
                sy = sb; ey = eb; my = {1'b1, fb};
            end
            d    = ex - ey;
            mx27 = {mx, 3'b000};
            // Shifted-out bits collapse into the sticky position.
            if (d >= 8'd54) begin
                aligned = 27'd1;
            end else begin
                w       = {my, 30'b0} >> d;
                aligned = {w[53:28], |w[27:0]};
            end
            if (sx == sy) begin
                sum = {1'b0, mx27} + {1'b0, aligned};
                if (sum[27])
                    fp_add = fp_round(sx, $signed({2'b00, ex}) + 10'sd1,
                                      {sum[27:2], sum[1] | sum[0]});
                else
                    fp_add = fp_round(sx, $signed({2'b00, ex}), sum[26:0]);
            end else begin
                diff = mx27 - aligned;
                if (diff == 27'b0) begin
                    fp_add = 32'b0;
                end else begin
                    lz    = 5'd0;
                    found = 1'b0;
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (diff[i]) found = 1'b1;
                            else         lz = lz + 5'd1;
                        end
                    end
                    norm   = diff << lz;
                    e      = $signed({2'b00, ex}) - $signed({5'b00000, lz});
                    fp_add = fp_round(sx, e, norm);
                end
            end
        end
    endfunction

    logic [63:0] res_p0;
    logic [63:0] out_p1;

    always_comb begin
        res_p0 = 64'b0;
        case (bus.opcode)
            OP_ADD:  res_p0 = {31'b0, {1'b0, bus.a} + {1'b0, bus.b}};
            OP_SUB:  res_p0 = {{32{bus.a[31]}}, bus.a} - {{32{bus.b[31]}}, bus.b};
            OP_MUL:  res_p0 = {32'b0, bus.a} * {32'b0, bus.b};
            OP_AND:  res_p0 = {32'b0, bus.a & bus.b};
            OP_OR:   res_p0 = {32'b0, bus.a | bus.b};
            OP_XOR:  res_p0 = {32'b0, bus.a ^ bus.b};
            OP_FADD: res_p0 = {32'b0, fp_add(bus.a, bus.b)};
            OP_FSUB: res_p0 = {32'b0, fp_add(bus.a, {~bus.b[31], bus.b[30:0]})};
            OP_SLL:  res_p0 = {32'b0, bus.a} << bus.b[4:0];
            OP_SRL:  res_p0 = {32'b0, bus.a >> bus.b[4:0]};
            OP_SLT:  res_p0 = {63'b0, $signed(bus.a) < $signed(bus.b)};
            default: res_p0 = 64'b0;
        endcase
    end

    // p0 -> p1: single output register
    always_ff @(posedge clk) begin
        if (rst) out_p1 <= 64'h0;
        else     out_p1 <= res_p0;
    end

    assign bus.out = out_p1;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor
// pops and compares one cycle later.
module tb_alu;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_FADD = 5'b00101;
    localparam logic [4:0] OP_FSUB = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SLT  = 5'b01010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_if bus ();

    alu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] mon_exp;
    string       mon_name;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (bus.out !== mon_exp) begin
                errors++;
                $display("FAIL %s got %h expected %h", mon_name, bus.out, mon_exp);
            end
        end
    end

    task automatic issue(input logic r, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] op, input logic [63:0] e, input string n);
        @(negedge clk);
        rst        = r;
        bus.a      = x;
        bus.b      = y;
        bus.opcode = op;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Reference binary32 add via exact double sum (operands kept within 20
    // binades of each other, normal range) then one RNE rounding to 24 bits.
    function automatic logic [31:0] ref_fadd(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] dx, dy, ds;
        real         rs;
        logic [22:0] m;
        logic [23:0] m24;
        logic        up;
        int          fe;
        dx = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0};
        dy = {y[31], 11'(int'(y[30:23]) + 896), y[22:0], 29'b0};
        rs = $bitstoreal(dx) + $bitstoreal(dy);
        ds = $realtobits(rs);
        if (ds[62:0] == 63'b0) return {ds[63], 31'b0};
        fe  = int'(ds[62:52]) - 896;
        m   = ds[51:29];
        up  = ds[28] & ((|ds[27:0]) | m[0]);
        m24 = {1'b0, m} + {23'b0, up};
        if (m24[23]) fe = fe + 1;
        return {ds[63], 8'(fe), m24[22:0]};
    endfunction

    logic [31:0] x, y;
    int          ex, ey;

    initial begin
        bus.a      = 32'hFFFFFFFF;
        bus.b      = 32'hFFFFFFFF;
        bus.opcode = OP_MUL;

        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 64'h0, "reset_0");
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 64'h0, "reset_1");
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 64'hFFFFFFFE00000001, "first_mul");

        issue(1'b0, 32'hFFFFFFFF, 32'h00000001, OP_ADD, 64'h0000000100000000, "add_carry");
        issue(1'b0, 32'h00000000, 32'h00000001, OP_SUB, 64'hFFFFFFFFFFFFFFFF, "sub_neg");
        issue(1'b0, 32'hFFFFFFFF, 32'h00000001, OP_SLT, 64'h1, "slt_true");
        issue(1'b0, 32'h00000001, 32'hFFFFFFFF, OP_SLT, 64'h0, "slt_false");
        issue(1'b0, 32'h00000001, 32'd31,       OP_SLL, 64'h0000000080000000, "sll_31");
        issue(1'b0, 32'h80000000, 32'd4,        OP_SRL, 64'h0000000008000000, "srl_4");
        issue(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 64'h00000000F000F000, "and");
        issue(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  64'h00000000FFF0FFF0, "or");
        issue(1'b0, 32'hF0F0F0F0, 32'hFF00FF00, OP_XOR, 64'h000000000FF00FF0, "xor");
        issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 5'b11111, 64'h0, "illegal_op");

        issue(1'b0, 32'h41900000, 32'h44F30000, OP_FADD, 64'h44F54000, "fadd_1962");
        issue(1'b0, 32'h3F800000, 32'h3F800000, OP_FADD, 64'h40000000, "fadd_1p1");
        issue(1'b0, 32'h3F800000, 32'h33800000, OP_FADD, 64'h3F800000, "fadd_tie_even");
        issue(1'b0, 32'h3F800000, 32'h33800001, OP_FADD, 64'h3F800001, "fadd_above_tie");
        issue(1'b0, 32'h3F800000, 32'h3F800000, OP_FSUB, 64'h00000000, "fsub_cancel");
        issue(1'b0, 32'h3F800000, 32'h3F000000, OP_FSUB, 64'h3F000000, "fsub_half");
        issue(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, OP_FADD, 64'h7F800000, "fadd_overflow");
        issue(1'b0, 32'h7F800000, 32'hFF800000, OP_FADD, 64'h7FC00000, "inf_minus_inf");
        issue(1'b0, 32'h7F800000, 32'h3F800000, OP_FADD, 64'h7F800000, "inf_plus_one");
        issue(1'b0, 32'h7FA00000, 32'h3F800000, OP_FADD, 64'h7FC00000, "nan_in");
        issue(1'b0, 32'h00000001, 32'h00000001, OP_FADD, 64'h00000000, "denormal");
        issue(1'b0, 32'h80000000, 32'h80000000, OP_FADD, 64'h80000000, "neg_zero");

        issue(1'b1, 32'h00000005, 32'h00000006, OP_ADD, 64'h0, "mid_reset");
        issue(1'b0, 32'h00000005, 32'h00000006, OP_ADD, 64'd11, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 2 == 0) begin
                ex = $urandom_range(140, 110);
                ey = ex + int'($urandom_range(40, 0)) - 20;
                x  = {x[31], 8'(ex), x[22:0]};
                y  = {y[31], 8'(ey), y[22:0]};
                issue(1'b0, x, y, OP_FADD, {32'b0, ref_fadd(x, y)}, "rand_fadd");
            end else begin
                issue(1'b0, x, y, OP_MUL, {32'b0, x} * {32'b0, y}, "rand_mul");
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Single-cycle registered 32-bit arithmetic/logic unit with integer operations and IEEE-754 single-precision add/subtract. It is the leaf compute element of the datapath: several instances are chained into adder trees, for example a series-summation tree built from opcode 5'b00101 FADD. Each instance takes two 32-bit operands and a 5-bit opcode and produces a 64-bit registered result.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A (integer or IEEE-754 single).
- b  input  32  operand B (integer or IEEE-754 single).
- opcode  input  5  operation select.
- out  output  64  registered result. FP results in out[31:0], with out[63:32] = 0.

## Operation
- 5'b00000 ADD: out = {31'b0, a + b}, i.e. the unsigned 33-bit sum.
- 5'b00001 SUB: out = sign-extended signed (a − b) to 64 bits.
- 5'b00010 MUL: out = unsigned 64-bit product a × b.
- 5'b00011 AND, 5'b00100 OR, 5'b00111 XOR: bitwise, zero-extended.
- 5'b00101 FADD: out[31:0] = a + b (binary32).
- 5'b00110 FSUB: out[31:0] = a − b, implemented as FADD with b sign inverted.
- 5'b01000 SLL: out = {32'b0, a} << b[4:0].
- 5'b01001 SRL: out = {32'b0, a >> b[4:0]}.
- 5'b01010 SLT: out = 1 if $signed(a) < $signed(b), else 0.
- All other opcodes: out = 0.
- FP rules:
  - Operand swap so |X| ≥ |Y|.
  - Align the smaller operand with guard, round and sticky bits.
  - Add or subtract mantissas, then normalise (1-bit right shift or leading-zero left shift).
  - Round to nearest, ties to even.
  - Denormal inputs are treated as signed zero. Results below the minimum normal flush to zero with the computed sign.
  - Exponent overflow gives ±Inf (0x7F800000 / 0xFF800000).
  - Any NaN input gives canonical 0x7FC00000. +Inf + −Inf gives 0x7FC00000.
  - Inf + finite gives that Inf.
  - Exact cancellation (x + −x) gives +0 (0x00000000). (−0) + (−0) gives 0x80000000.
- All arithmetic is combinational into a single output register. No flags and no exceptions are reported.

## Timing
- On each rising clk edge: if rst = 1, out ← 64'h0; otherwise out ← f(a, b, opcode) sampled at that edge.
- Latency is exactly 1 cycle. Throughput is one operation per cycle.
- There is no handshake and no valid signal. out holds its value until the next edge.
- rst asserted mid-stream clears out on that edge regardless of opcode. The first result after reset deasserts appears on the first edge with rst = 0.
- Opcode or operands changing every cycle must produce independent results with no state carried over.
- Chained instances add 1 cycle per tree level. A 3-level tree gives its result 3 cycles after inputs are stable.

## Test plan
- Reset: hold rst = 1 for 2 cycles with a = 0xFFFFFFFF, b = 0xFFFFFFFF, opcode = MUL -> out = 0. First edge after release -> out = 0xFFFFFFFE00000001.
- Integer: ADD 0xFFFFFFFF + 1 -> 0x0000000100000000. SUB 0 − 1 -> 0xFFFFFFFFFFFFFFFF. SLT 0xFFFFFFFF vs 1 -> 1. SLL 1 by 31 -> 0x0000000080000000. Opcode 5'b11111 -> 0.
- FADD basic: 0x41900000 (18.0) + 0x44F30000 (1944.0) -> out[31:0] = 0x44F54000 (1962.0). 0x3F800000 + 0x3F800000 -> 0x40000000.
- FADD rounding: 0x3F800000 + 0x33800000 (tie) -> 0x3F800000. 0x3F800000 + 0x33800001 -> 0x3F800001.
- FP specials:
  - FSUB 0x3F800000 − 0x3F800000 -> 0x00000000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - NaN 0x7FA00000 + 1.0 -> 0x7FC00000.
  - Denormal 0x00000001 + 0x00000001 -> 0x00000000.
- Back-to-back: alternate FADD and MUL every cycle with random operands for 1000 cycles. Compare each out against a reference model delayed by 1 cycle; out[63:32] must be 0 on every FP result.
